pseudo_proc_raster: RTL and testbench

Single-triangle flat-shaded rasterizer. It accepts one 256-bit triangle descriptor per handshake and scan-converts it into a 640x480 frame buffer held in external asynchronous 16-bit SRAM. It pulses a finish flag when the triangle is complete. It sits between the PCIe command path, which delivers triangles, and the SRAM frame buffer, which video scan-out reads.

---
 rtl/pseudo_proc_pkg.sv | 51 +++++
 rtl/pseudo_proc_edge.sv | 30 +++
 rtl/pseudo_proc_raster.sv | 222 ++++++++++++++++++++++
 tb/tb_pseudo_proc_raster.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pseudo_proc_pkg.sv
// Shared constants, vertex layout, FSM states and the edge-function helper
// for the flat-shaded triangle rasterizer.
package pseudo_proc_pkg;

    localparam int unsigned FB_W   = 640;
    localparam int unsigned FB_H   = 480;
    localparam int unsigned XW     = 10;
    localparam int unsigned YW     = 9;
    localparam int unsigned AW     = 20;
    localparam int unsigned DW     = 16;
    localparam int unsigned CW     = 16;
    localparam int unsigned VTX_W  = 80;
    localparam int unsigned V0_LSB = 160;
    localparam int unsigned V1_LSB = 80;
    localparam int unsigned V2_LSB = 0;
    localparam int unsigned RSV_LSB = 240;

    typedef struct packed {
        logic [7:0]    pad;
        logic [7:0]    r;
        logic [7:0]    g;
        logic [7:0]    b;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [CW-1:0] z;
    } vertex_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_AREA,
        ST_SCAN,
        ST_WR0,
        ST_WR1,
        ST_DONE
    } state_t;

    // E = (px-xa)(yb-ya) - (py-ya)(xb-xa), 17-bit signed deltas, 35-bit result
    function automatic logic signed [34:0] edge_fn(
        input logic [CW-1:0] px, input logic [CW-1:0] py,
        input logic [CW-1:0] xa, input logic [CW-1:0] ya,
        input logic [CW-1:0] xb, input logic [CW-1:0] yb);
        logic signed [16:0] dxp, dyp, dxe, dye;
        dxp = $signed({1'b0, px}) - $signed({1'b0, xa});
        dyp = $signed({1'b0, py}) - $signed({1'b0, ya});
        dxe = $signed({1'b0, xb}) - $signed({1'b0, xa});
        dye = $signed({1'b0, yb}) - $signed({1'b0, ya});
        return (35'(dxp) * 35'(dye)) - (35'(dyp) * 35'(dxe));
    endfunction

endpackage

// File: rtl/pseudo_proc_edge.sv
// Combinational coverage test of one pixel against the three triangle edges;
// a pixel is inside when all edge values share a sign (zero counts as both).
module pseudo_proc_edge
    import pseudo_proc_pkg::*;
(
    input  logic [15:0] px_i,
    input  logic [15:0] py_i,
    input  logic [15:0] x0_i,
    input  logic [15:0] y0_i,
    input  logic [15:0] x1_i,
    input  logic [15:0] y1_i,
    input  logic [15:0] x2_i,
    input  logic [15:0] y2_i,
    output logic        covered_c
);

    logic signed [34:0] e01, e12, e20;
    logic               all_ge, all_le;

    always_comb begin
        e01    = edge_fn(px_i, py_i, x0_i, y0_i, x1_i, y1_i);
        e12    = edge_fn(px_i, py_i, x1_i, y1_i, x2_i, y2_i);
        e20    = edge_fn(px_i, py_i, x2_i, y2_i, x0_i, y0_i);
        all_ge = !e01[34] && !e12[34] && !e20[34];
        all_le = (e01[34] || (e01 == '0)) && (e12[34] || (e12 == '0))
              && (e20[34] || (e20 == '0));
        covered_c = all_ge || all_le;
    end

endmodule

// File: rtl/pseudo_proc_raster.sv
// Single-triangle flat-shaded rasterizer writing a 640x480 two-word-per-pixel
// frame buffer in async SRAM. PSEUDO_PROC_CULL_EN culls clockwise triangles.
module pseudo_proc_raster
    import pseudo_proc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    output logic          o_proc_ready,
    input  logic          i_triangle_valid,
    input  logic [255:0]  i_triangle_data,
    output logic [19:0]   o_sram_addr,
    inout  wire  [15:0]   io_sram_data,
    output logic          o_sram_we_n,
    output logic          o_sram_oe_n,
    output logic          o_proc_finish
);

    state_t        state_q, state_d;
    logic [CW-1:0] x0_q, y0_q, x1_q, y1_q, x2_q, y2_q;
    logic [CW-1:0] x0_d, y0_d, x1_d, y1_d, x2_d, y2_d;
    logic [7:0]    r_q, g_q, b_q, r_d, g_d, b_d;
    logic [XW-1:0] xmin_q, xmax_q, x_q, xmin_d, xmax_d, x_d;
    logic [YW-1:0] ymin_q, ymax_q, y_q, ymin_d, ymax_d, y_d;
    logic [1:0]    slot_q, slot_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          we_n_q, we_n_d, drv_q, drv_d;
    logic          ready_q, ready_d, finish_q, finish_d;

    vertex_t            v0_w, v1_w, v2_w;
    logic signed [34:0] area;
    logic               covered;
    logic               last_px;
    logic [AW-1:0]      pix_base;
    logic [XW-1:0]      bx_lo, bx_hi;
    logic [YW-1:0]      by_lo, by_hi;
    logic               unused_desc;

    function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c);
        logic [CW-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c);
        logic [CW-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [CW-1:0] clamp(input logic [CW-1:0] v, input logic [CW-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    assign v0_w = i_triangle_data[V0_LSB +: VTX_W];
    assign v1_w = i_triangle_data[V1_LSB +: VTX_W];
    assign v2_w = i_triangle_data[V2_LSB +: VTX_W];
    assign unused_desc = ^{i_triangle_data[255:RSV_LSB], v0_w.pad, v0_w.z,
                           v1_w.pad, v1_w.r, v1_w.g, v1_w.b, v1_w.z,
                           v2_w.pad, v2_w.r, v2_w.g, v2_w.b, v2_w.z};

    // Bounding box clamped to the frame; a fully off-screen box collapses to the
    // border where the edge test rejects every pixel.
    assign bx_lo = XW'(clamp(min3(x0_q, x1_q, x2_q), CW'(FB_W - 1)));
    assign bx_hi = XW'(clamp(max3(x0_q, x1_q, x2_q), CW'(FB_W - 1)));
    assign by_lo = YW'(clamp(min3(y0_q, y1_q, y2_q), CW'(FB_H - 1)));
    assign by_hi = YW'(clamp(max3(y0_q, y1_q, y2_q), CW'(FB_H - 1)));

    assign area     = edge_fn(x1_q, y1_q, x0_q, y0_q, x2_q, y2_q);
    assign last_px  = (x_q == xmax_q) && (y_q == ymax_q);
    assign pix_base = (AW'(y_q) * AW'(FB_W) + AW'(x_q)) << 1;

    pseudo_proc_edge u_edge (
        .px_i      (CW'(x_q)),
        .py_i      (CW'(y_q)),
        .x0_i      (x0_q),
        .y0_i      (y0_q),
        .x1_i      (x1_q),
        .y1_i      (y1_q),
        .x2_i      (x2_q),
        .y2_i      (y2_q),
        .covered_c (covered)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        x0_d = x0_q; y0_d = y0_q; x1_d = x1_q; y1_d = y1_q; x2_d = x2_q; y2_d = y2_q;
        r_d = r_q; g_d = g_q; b_d = b_q;
        xmin_d = xmin_q; xmax_d = xmax_q; ymin_d = ymin_q; ymax_d = ymax_q;
        x_d      = x_q;
        y_d      = y_q;
        slot_d   = slot_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_n_d   = 1'b1;
        drv_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_triangle_valid) begin
                    x0_d = v0_w.x; y0_d = v0_w.y;
                    x1_d = v1_w.x; y1_d = v1_w.y;
                    x2_d = v2_w.x; y2_d = v2_w.y;
                    r_d = v0_w.r; g_d = v0_w.g; b_d = v0_w.b;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                xmin_d  = bx_lo;
                xmax_d  = bx_hi;
                ymin_d  = by_lo;
                ymax_d  = by_hi;
                x_d     = bx_lo;
                y_d     = by_lo;
                state_d = ST_AREA;
            end
            ST_AREA: begin
`ifdef PSEUDO_PROC_CULL_EN
                if ((area == '0) || area[34]) state_d = ST_DONE;
`else
                if (area == '0) state_d = ST_DONE;
`endif
                else state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (covered) begin
                    state_d = ST_WR0;
                    slot_d  = 2'd0;
                    we_n_d  = 1'b0;
                    drv_d   = 1'b1;
                    addr_d  = pix_base;
                    data_d  = {r_q, g_q};
                end else if (last_px) begin
                    state_d = ST_DONE;
                end else if (x_q == xmax_q) begin
                    x_d = xmin_q;
                    y_d = y_q + YW'(1);
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
            ST_WR0: begin
                drv_d = 1'b1;
                if (slot_q == 2'd2) begin
                    state_d = ST_WR1;
                    slot_d  = 2'd0;
                    we_n_d  = 1'b0;
                    addr_d  = addr_q + AW'(1);
                    data_d  = {8'h00, b_q};
                end else begin
                    slot_d = slot_q + 2'd1;
                end
            end
            ST_WR1: begin
                if (slot_q == 2'd2) begin
                    if (last_px) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SCAN;
                        if (x_q == xmax_q) begin
                            x_d = xmin_q;
                            y_d = y_q + YW'(1);
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                    end
                end else begin
                    drv_d  = 1'b1;
                    slot_d = slot_q + 2'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ready_d  = (state_d == ST_IDLE);
        finish_d = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            x0_q <= '0; y0_q <= '0; x1_q <= '0; y1_q <= '0; x2_q <= '0; y2_q <= '0;
            r_q <= '0; g_q <= '0; b_q <= '0;
            xmin_q <= '0; xmax_q <= '0; ymin_q <= '0; ymax_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            slot_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_n_q   <= 1'b1;
            drv_q    <= 1'b0;
            ready_q  <= 1'b1;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q <= x0_d; y0_q <= y0_d; x1_q <= x1_d; y1_q <= y1_d; x2_q <= x2_d; y2_q <= y2_d;
            r_q <= r_d; g_q <= g_d; b_q <= b_d;
            xmin_q <= xmin_d; xmax_q <= xmax_d; ymin_q <= ymin_d; ymax_q <= ymax_d;
            x_q      <= x_d;
            y_q      <= y_d;
            slot_q   <= slot_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_n_q   <= we_n_d;
            drv_q    <= drv_d;
            ready_q  <= ready_d;
            finish_q <= finish_d;
        end
    end

    assign o_proc_ready  = ready_q;
    assign o_proc_finish = finish_q;
    assign o_sram_addr   = addr_q;
    assign o_sram_we_n   = we_n_q;
    assign o_sram_oe_n   = 1'b1;
    assign io_sram_data  = drv_q ? data_q : 16'hzzzz;

endmodule

// File: tb/tb_pseudo_proc_raster.sv
// Bench for pseudo_proc_raster: directed triangle table plus random triangles
// checked against a loop-based raster model and an SRAM write monitor.
module tb_pseudo_proc_raster;

    logic         clk = 1'b0;
    logic         rst;
    logic         ready;
    logic         valid;
    logic [255:0] tri_data;
    logic [19:0]  addr;
    wire  [15:0]  sram_data;
    logic         we_n;
    logic         oe_n;
    logic         finish;

    int total = 0;
    int bad   = 0;
    int fin_cnt = 0;
    int hold_n = 0;
    logic [19:0] h_addr;
    logic [15:0] h_data;
    logic [35:0] wq[$];
    logic [35:0] exp_q[$];

    pseudo_proc_raster dut (
        .clk              (clk),
        .rst              (rst),
        .o_proc_ready     (ready),
        .i_triangle_valid (valid),
        .i_triangle_data  (tri_data),
        .o_sram_addr      (addr),
        .io_sram_data     (sram_data),
        .o_sram_we_n      (we_n),
        .o_sram_oe_n      (oe_n),
        .o_proc_finish    (finish)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, act, exp);
        end
    endtask

    // SRAM side: log each write strobe and check the 3-cycle hold of addr/data
    always @(negedge clk) begin
        if (rst) begin
            hold_n = 0;
        end else begin
            if (hold_n > 0) begin
                chk("hold_we_n", longint'(we_n), 1);
                chk("hold_addr", longint'(addr), longint'(h_addr));
                chk("hold_data", longint'(sram_data), longint'(h_data));
                hold_n--;
            end
            if (we_n == 1'b0) begin
                wq.push_back({addr, sram_data});
                if (addr > 20'd614399) chk("addr_range", longint'(addr), 614399);
                hold_n = 2;
                h_addr = addr;
                h_data = sram_data;
            end
            if (finish) fin_cnt++;
        end
    end

    function automatic longint ef(input longint px, input longint py, input longint xa,
                                  input longint ya, input longint xb, input longint yb);
        return (px - xa) * (yb - ya) - (py - ya) * (xb - xa);
    endfunction

    function automatic int mn3c(input int a, input int b, input int c, input int lim);
        int m;
        m = a; if (b < m) m = b; if (c < m) m = c;
        return (m > lim) ? lim : m;
    endfunction

    function automatic int mx3c(input int a, input int b, input int c, input int lim);
        int m;
        m = a; if (b > m) m = b; if (c > m) m = c;
        return (m > lim) ? lim : m;
    endfunction

    // Reference raster: expected write list and finish latency
    task automatic model(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b, output int lat);
        longint a, e0, e1, e2;
        int w;
        exp_q.delete();
        lat = 4;
        a = ef(x1, y1, x0, y0, x2, y2);
        if (a == 0) return;
`ifdef PSEUDO_PROC_CULL_EN
        if (a < 0) return;
`endif
        for (int y = mn3c(y0, y1, y2, 479); y <= mx3c(y0, y1, y2, 479); y++) begin
            for (int x = mn3c(x0, x1, x2, 639); x <= mx3c(x0, x1, x2, 639); x++) begin
                lat++;
                e0 = ef(x, y, x0, y0, x1, y1);
                e1 = ef(x, y, x1, y1, x2, y2);
                e2 = ef(x, y, x2, y2, x0, y0);
                if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0)) begin
                    w = (y * 640 + x) * 2;
                    exp_q.push_back({20'(w), r, g});
                    exp_q.push_back({20'(w + 1), 8'h00, b});
                    lat += 6;
                end
            end
        end
    endtask

    function automatic logic [255:0] mk(input int x0, input int y0, input int x1, input int y1,
                                        input int x2, input int y2, input logic [7:0] r,
                                        input logic [7:0] g, input logic [7:0] b);
        return {16'hBEEF,
                8'hAA, r, g, b, 16'(x0), 16'(y0), 16'h1234,
                8'h55, ~r, ~g, ~b, 16'(x1), 16'(y1), 16'h5678,
                8'h0F, g, b, r, 16'(x2), 16'(y2), 16'h9ABC};
    endfunction

    function automatic int find(input logic [19:0] a);
        for (int i = 0; i < wq.size(); i++)
            if (wq[i][35:16] == a) return int'(wq[i][15:0]);
        return -1;
    endfunction

    task automatic run_tri(input logic [255:0] d, input int exp_lat, input int busy_at,
                           input logic [255:0] bd);
        int k, f0;
        for (int i = 0; i < 50 && !ready; i++) @(negedge clk);
        chk("ready_before", longint'(ready), 1);
        wq.delete();
        f0 = fin_cnt;
        valid = 1'b1;
        tri_data = d;
        @(negedge clk);
        valid = 1'b0;
        k = 1;
        chk("ready_drop", longint'(ready), 0);
        while (!finish && k < 20000) begin
            if (busy_at > 0 && k == busy_at) begin
                valid = 1'b1;
                tri_data = bd;
            end else begin
                valid = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        valid = 1'b0;
        chk("latency", k, exp_lat);
        chk("ready_at_finish", longint'(ready), 1);
        @(negedge clk);
        chk("finish_one_cycle", longint'(finish), 0);
        chk("finish_count", fin_cnt - f0, 1);
    endtask

    task automatic cmp_writes(input string name);
        int miss;
        miss = 0;
        chk({name, "_nwrites"}, wq.size(), exp_q.size());
        for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
            if (wq[i] != exp_q[i]) miss++;
        chk({name, "_words"}, miss, 0);
    endtask

    typedef struct {
        int x0, y0, x1, y1, x2, y2;
        int exp_pix;
        int exp_lat;
    } vec_t;

    initial begin
        vec_t vt[4];
        int lat, n0;
        logic [255:0] basic_d;

        vt[0] = '{10, 10, 13, 10, 10, 13, 10, 80};
`ifdef PSEUDO_PROC_CULL_EN
        vt[1] = '{10, 10, 10, 13, 13, 10, 0, 4};
`else
        vt[1] = '{10, 10, 10, 13, 13, 10, 10, 80};
`endif
        vt[2] = '{0, 0, 5, 0, 9, 0, 0, 4};
        vt[3] = '{630, 470, 700, 470, 630, 520, 100, 704};

        valid = 1'b0;
        tri_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", longint'(ready), 1);
        chk("rst_we_n", longint'(we_n), 1);
        chk("rst_oe_n", longint'(oe_n), 1);
        chk("rst_finish", longint'(finish), 0);
        chk("rst_addr", longint'(addr), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_tri(mk(vt[i].x0, vt[i].y0, vt[i].x1, vt[i].y1, vt[i].x2, vt[i].y2,
                       8'hC1, 8'hC1, 8'hC1), vt[i].exp_lat, 0, '0);
            chk("table_nwrites", wq.size(), 2 * vt[i].exp_pix);
            model(vt[i].x0, vt[i].y0, vt[i].x1, vt[i].y1, vt[i].x2, vt[i].y2,
                  8'hC1, 8'hC1, 8'hC1, lat);
            cmp_writes("table");
            if (i == 0) begin
                chk("basic_w12820", find(20'd12820), 32'hC1C1);
                chk("basic_w12821", find(20'd12821), 32'h00C1);
                chk("basic_px14_10", find(20'd12828), -1);
            end
            if (i == 3) begin
                chk("clip_w614398", find(20'd614398), 32'hC1C1);
                chk("clip_w614399", find(20'd614399), 32'h00C1);
            end
        end

        // Second descriptor pulsed mid-scan must be dropped
        basic_d = mk(10, 10, 13, 10, 10, 13, 8'h12, 8'h34, 8'h56);
        model(10, 10, 13, 10, 10, 13, 8'h12, 8'h34, 8'h56, lat);
        run_tri(basic_d, lat, 6, mk(20, 20, 25, 20, 20, 25, 8'hEE, 8'hEE, 8'hEE));
        cmp_writes("busy");
        n0 = wq.size();
        repeat (20) @(negedge clk);
        chk("busy_no_extra", wq.size(), n0);
        chk("busy_ready_idle", longint'(ready), 1);

        // Random triangles, some straddling the right/bottom border
        for (int t = 0; t < 10; t++) begin
            int bx, by, xs[3], ys[3];
            logic [7:0] r, g, b;
            bx = $urandom_range(0, 640);
            by = $urandom_range(0, 480);
            for (int v = 0; v < 3; v++) begin
                xs[v] = bx + $urandom_range(0, 15);
                ys[v] = by + $urandom_range(0, 15);
            end
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
            model(xs[0], ys[0], xs[1], ys[1], xs[2], ys[2], r, g, b, lat);
            run_tri(mk(xs[0], ys[0], xs[1], ys[1], xs[2], ys[2], r, g, b), lat, 0, '0);
            cmp_writes("rand");
        end

        // Reset in the middle of a long draw: no writes afterwards
        valid = 1'b1;
        tri_data = mk(630, 470, 700, 470, 630, 520, 8'h77, 8'h88, 8'h99);
        @(negedge clk);
        valid = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n0 = wq.size();
        chk("abort_started", longint'(n0 > 0), 1);
        repeat (30) @(negedge clk);
        chk("abort_no_writes", wq.size(), n0);
        chk("abort_ready", longint'(ready), 1);
        chk("abort_we_n", longint'(we_n), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
